// File: rtl/uart_rx_ip_if.sv
// Local-bus interface for uart_rx_ip.
// Write channel: waddr/wdata/wen/wstrb from the processor, wready back.
// Read channel:  raddr/ren from the processor, rdata/rvalid back.
// master = processor side, slave = peripheral side.
interface uart_rx_ip_if;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        wen;
  logic [3:0]  wstrb;
  logic        wready;
  logic [31:0] raddr;
  logic        ren;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (
    output waddr, wdata, wen, wstrb, raddr, ren,
    input  wready, rdata, rvalid
  );

  modport slave (
    input  waddr, wdata, wen, wstrb, raddr, ren,
    output wready, rdata, rvalid
  );
endinterface

// File: rtl/uart_rx_ip.sv
// uart_rx_ip: memory-mapped 8N1 UART receiver with a small receive FIFO.
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   bus       local bus, slave side (DATA 0x0, STATUS 0x4, DIV 0x8)
//   i_uart_rx asynchronous serial input, idle high
//   o_rx_irq  high while the FIFO holds data
//
// state   | meaning
// IDLE    | line idle, waiting for a falling edge
// START   | waiting for the middle of the start bit to confirm it
// DATA    | sampling 8 data bits, LSB first
// STOP    | waiting for the middle of the stop bit
// BREAK   | bad stop bit seen, waiting for the line to return high
module uart_rx_ip #(
  parameter logic [15:0] DEFAULT_DIV = 16'd234,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  uart_rx_ip_if.slave bus,
  input  logic        i_uart_rx,
  output logic        o_rx_irq
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          r_rx_meta, r_rx_s;
  logic [2:0]    r_state;
  logic [15:0]   r_tmr, r_div, r_div_q;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_overrun, r_frame_err;
  logic [31:0]   r_rdata;
  logic          r_rvalid, r_wready;

  logic [3:0]  w_wr_off, w_rd_off;
  logic        w_tmr_zero, w_full, w_pop, w_push_req, w_push, w_ovr_set, w_fe_set;
  logic        w_div_wr, w_st_wr;
  logic [15:0] w_div_merge, w_div_new;
  logic [31:0] w_status, w_rd_mux;
  logic        w_unused_bits;

  assign w_wr_off   = bus.waddr[3:0];
  assign w_rd_off   = bus.raddr[3:0];
  assign w_tmr_zero = (r_tmr == 16'd0);
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_pop      = bus.ren && (w_rd_off == 4'h0) && (r_count != '0);
  assign w_push_req = (r_state == S_STOP) && w_tmr_zero && r_rx_s;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovr_set  = w_push_req && w_full && !w_pop;
  assign w_fe_set   = (r_state == S_STOP) && w_tmr_zero && !r_rx_s;
  assign w_div_wr   = bus.wen && (w_wr_off == 4'h8);
  assign w_st_wr    = bus.wen && (w_wr_off == 4'h4) && bus.wstrb[0];

  assign w_div_merge = {bus.wstrb[1] ? bus.wdata[15:8] : r_div[15:8],
                        bus.wstrb[0] ? bus.wdata[7:0]  : r_div[7:0]};
  assign w_div_new   = (w_div_merge < 16'd4) ? 16'd4 : w_div_merge;

  assign w_unused_bits = ^{bus.waddr[31:4], bus.raddr[31:4], bus.wdata[31:16], bus.wstrb[3:2]};

  always_comb begin
    w_status           = 32'd0;
    w_status[0]        = (r_count != '0);
    w_status[1]        = w_full;
    w_status[2]        = r_overrun;
    w_status[3]        = r_frame_err;
    w_status[8 +: CW]  = r_count;
  end

  always_comb begin
    w_rd_mux = 32'd0;
    case (w_rd_off)
      4'h0:    if (r_count != '0) w_rd_mux[7:0] = r_mem[r_rptr];
      4'h4:    w_rd_mux = w_status;
      4'h8:    w_rd_mux[15:0] = r_div;
      default: w_rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_uart_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // The timer counts down to zero inclusive, so a reload of div_q-1 gives
  // exactly div_q clocks per bit; the start bit uses div_q/2 to land mid-bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_tmr   <= 16'd0;
      r_div_q <= DEFAULT_DIV;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: if (!r_rx_s) begin
          r_div_q <= r_div;
          r_tmr   <= r_div >> 1;
          r_state <= S_START;
        end
        S_START: if (w_tmr_zero) begin
          if (r_rx_s) r_state <= S_IDLE;
          else begin
            r_tmr   <= r_div_q - 16'd1;
            r_bit   <= 3'd0;
            r_state <= S_DATA;
          end
        end else r_tmr <= r_tmr - 16'd1;
        S_DATA: if (w_tmr_zero) begin
          r_shift <= {r_rx_s, r_shift[7:1]};
          r_tmr   <= r_div_q - 16'd1;
          r_bit   <= r_bit + 3'd1;
          if (r_bit == 3'd7) r_state <= S_STOP;
        end else r_tmr <= r_tmr - 16'd1;
        S_STOP: if (w_tmr_zero) r_state <= r_rx_s ? S_IDLE : S_BREAK;
                else r_tmr <= r_tmr - 16'd1;
        S_BREAK: if (r_rx_s) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a W1C wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_div       <= DEFAULT_DIV;
      r_wready    <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rdata     <= 32'd0;
    end else begin
      r_overrun   <= w_ovr_set | (r_overrun   & ~(w_st_wr & bus.wdata[2]));
      r_frame_err <= w_fe_set  | (r_frame_err & ~(w_st_wr & bus.wdata[3]));
      if (w_div_wr) r_div <= w_div_new;
      r_wready <= bus.wen;
      r_rvalid <= bus.ren;
      if (bus.ren) r_rdata <= w_rd_mux;
    end
  end

  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;
  assign bus.wready = r_wready;
  assign o_rx_irq   = (r_count != '0);

endmodule
